// File: rtl/parking_gate_ctrl_if.sv
// Gate-sensor side and Parking side of the gate controller, bundled as one bus.
// Requests are levels held until the car leaves the sensor; every pulse output is exactly one cycle wide.
interface parking_gate_ctrl_if #(
   parameter int CNT_W = 10
);
   logic             entry_req;
   logic             entry_is_uni;
   logic             exit_req;
   logic             exit_is_uni;
   logic             ja_nist;
   logic             faulty_exit;
   logic             car_entered;
   logic             is_uni_car_entered;
   logic             car_exited;
   logic             is_uni_car_exited;
   logic             entry_gate_open;
   logic             exit_gate_open;
   logic             entry_denied;
   logic             exit_denied;
   logic [CNT_W-1:0] entry_ok_cnt;
   logic [CNT_W-1:0] entry_deny_cnt;
   logic [CNT_W-1:0] exit_ok_cnt;
   logic [CNT_W-1:0] exit_deny_cnt;
   // Debug view of both FSMs, 0 = IDLE.
   logic [2:0]       entry_state;
   logic [2:0]       exit_state;

   modport slave (
      input  entry_req, entry_is_uni, exit_req, exit_is_uni, ja_nist, faulty_exit,
      output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
             entry_gate_open, exit_gate_open, entry_denied, exit_denied,
             entry_ok_cnt, entry_deny_cnt, exit_ok_cnt, exit_deny_cnt,
             entry_state, exit_state
   );

   modport master (
      output entry_req, entry_is_uni, exit_req, exit_is_uni, ja_nist, faulty_exit,
      input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
             entry_gate_open, exit_gate_open, entry_denied, exit_denied,
             entry_ok_cnt, entry_deny_cnt, exit_ok_cnt, exit_deny_cnt,
             entry_state, exit_state
   );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: one Moore FSM per gate turns a level request into a
// single pulse to Parking, then opens the barrier or denies the car from Parking's reply.
module parking_gate_fsm #(
   parameter int OPEN_CYCLES = 4,
   parameter int CNT_W       = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_req,
   input  logic             i_uni,
   input  logic             i_go,
   input  logic             i_resp,
   output logic             o_pulse,
   output logic             o_uni,
   output logic             o_open,
   output logic             o_denied,
   output logic [CNT_W-1:0] o_ok_cnt,
   output logic [CNT_W-1:0] o_deny_cnt,
   output logic [2:0]       o_state
);
   localparam int OW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
   localparam logic [OW-1:0] OPEN_LOAD = OW'(OPEN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_CHECK   = 3'd2,
      S_OPEN    = 3'd3,
      S_DENY    = 3'd4,
      S_RELEASE = 3'd5
   } state_t;

   state_t           r_state;
   logic             r_pulse;
   logic             r_uni;
   logic             r_open;
   logic             r_denied;
   logic [OW-1:0]    r_open_cnt;
   logic [CNT_W-1:0] r_ok_cnt;
   logic [CNT_W-1:0] r_deny_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_pulse    <= 1'b0;
         r_uni      <= 1'b0;
         r_open     <= 1'b0;
         r_denied   <= 1'b0;
         r_open_cnt <= '0;
         r_ok_cnt   <= '0;
         r_deny_cnt <= '0;
      end else begin
         r_pulse  <= 1'b0;
         r_uni    <= 1'b0;
         r_denied <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_req && i_go) begin
                  r_state <= S_ISSUE;
                  r_pulse <= 1'b1;
                  r_uni   <= i_uni;
               end
            end
            S_ISSUE: r_state <= S_CHECK;
            // Parking's reply reflects the pulse by the end of CHECK.
            S_CHECK: begin
               if (i_resp) begin
                  r_state  <= S_DENY;
                  r_denied <= 1'b1;
                  if (r_deny_cnt != '1) r_deny_cnt <= r_deny_cnt + 1'b1;
               end else begin
                  r_state    <= S_OPEN;
                  r_open     <= 1'b1;
                  r_open_cnt <= OPEN_LOAD;
                  if (r_ok_cnt != '1) r_ok_cnt <= r_ok_cnt + 1'b1;
               end
            end
            S_OPEN: begin
               if (r_open_cnt == '0) begin
                  r_state <= S_RELEASE;
                  r_open  <= 1'b0;
               end else begin
                  r_open_cnt <= r_open_cnt - 1'b1;
               end
            end
            S_DENY: r_state <= S_RELEASE;
            S_RELEASE: begin
               if (!i_req) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_pulse    = r_pulse;
   assign o_uni      = r_uni;
   assign o_open     = r_open;
   assign o_denied   = r_denied;
   assign o_ok_cnt   = r_ok_cnt;
   assign o_deny_cnt = r_deny_cnt;
   assign o_state    = r_state;
endmodule

module parking_gate_ctrl #(
   parameter int OPEN_CYCLES = 4,
   parameter int CNT_W       = 10
) (
   input  logic                 clock,
   input  logic                 reset,
   parking_gate_ctrl_if.slave   bus
);
   localparam logic [2:0] ST_IDLE = 3'd0;

   logic w_x_start;
   logic w_e_go;

   // Exit wins a same-edge tie so a leaving car frees its space first.
   assign w_x_start = (bus.exit_state == ST_IDLE) && bus.exit_req;
   assign w_e_go    = !w_x_start;

   parking_gate_fsm #(.OPEN_CYCLES(OPEN_CYCLES), .CNT_W(CNT_W)) u_entry (
      .clock      (clock),
      .reset      (reset),
      .i_req      (bus.entry_req),
      .i_uni      (bus.entry_is_uni),
      .i_go       (w_e_go),
      .i_resp     (bus.ja_nist),
      .o_pulse    (bus.car_entered),
      .o_uni      (bus.is_uni_car_entered),
      .o_open     (bus.entry_gate_open),
      .o_denied   (bus.entry_denied),
      .o_ok_cnt   (bus.entry_ok_cnt),
      .o_deny_cnt (bus.entry_deny_cnt),
      .o_state    (bus.entry_state)
   );

   parking_gate_fsm #(.OPEN_CYCLES(OPEN_CYCLES), .CNT_W(CNT_W)) u_exit (
      .clock      (clock),
      .reset      (reset),
      .i_req      (bus.exit_req),
      .i_uni      (bus.exit_is_uni),
      .i_go       (1'b1),
      .i_resp     (bus.faulty_exit),
      .o_pulse    (bus.car_exited),
      .o_uni      (bus.is_uni_car_exited),
      .o_open     (bus.exit_gate_open),
      .o_denied   (bus.exit_denied),
      .o_ok_cnt   (bus.exit_ok_cnt),
      .o_deny_cnt (bus.exit_deny_cnt),
      .o_state    (bus.exit_state)
   );
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed scenarios with literal expectations plus
// random traffic checked every cycle against a transaction-level model.
module tb_parking_gate_ctrl;
   localparam int OC   = 4;
   localparam int CW   = 2;
   localparam int MAXC = (1 << CW) - 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   parking_gate_ctrl_if #(.CNT_W(CW)) bus ();
   parking_gate_ctrl #(.OPEN_CYCLES(OC), .CNT_W(CW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: side 0 = entry, 1 = exit. One transaction record per side.
   int m_edge;
   int m_acc[2], m_rel[2], m_free[2], m_ok[2], m_dn[2];
   bit m_busy[2], m_wait[2], m_dec[2], m_deny[2], m_uni[2];

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_edge = -1;
         for (int s = 0; s < 2; s++) begin
            m_acc[s] = -100; m_rel[s] = 0; m_free[s] = 0; m_ok[s] = 0; m_dn[s] = 0;
            m_busy[s] = 0; m_wait[s] = 0; m_dec[s] = 0; m_deny[s] = 0; m_uni[s] = 0;
         end
      end else begin
         bit x_acc;
         bit req[2], resp[2], uni_in[2];
         m_edge++;
         req[0] = bus.entry_req;  resp[0] = bus.ja_nist;     uni_in[0] = bus.entry_is_uni;
         req[1] = bus.exit_req;   resp[1] = bus.faulty_exit; uni_in[1] = bus.exit_is_uni;
         x_acc = 0;
         for (int s = 1; s >= 0; s--) begin
            if (m_busy[s] && !m_wait[s] && m_edge == m_acc[s] + 2) begin
               m_dec[s]  = 1;
               m_deny[s] = resp[s];
               if (resp[s]) begin
                  if (m_dn[s] < MAXC) m_dn[s]++;
               end else begin
                  if (m_ok[s] < MAXC) m_ok[s]++;
               end
               m_rel[s]  = m_edge + (resp[s] ? 2 : OC + 1);
               m_wait[s] = 1;
            end else if (m_wait[s] && m_edge >= m_rel[s] && !req[s]) begin
               m_busy[s] = 0;
               m_wait[s] = 0;
               m_free[s] = m_edge + 1;
            end
            if (!m_busy[s] && m_edge >= m_free[s] && req[s] && !(s == 0 && x_acc)) begin
               m_busy[s] = 1;
               m_acc[s]  = m_edge;
               m_dec[s]  = 0;
               m_uni[s]  = uni_in[s];
               if (s == 1) x_acc = 1;
            end
         end
      end
   end

   function automatic bit exp_pulse(input int s, input int cur);
      return cur == m_acc[s] + 1;
   endfunction
   function automatic bit exp_open(input int s, input int cur);
      return m_dec[s] && !m_deny[s] && cur >= m_acc[s] + 3 && cur <= m_acc[s] + 2 + OC;
   endfunction
   function automatic bit exp_denied(input int s, input int cur);
      return m_dec[s] && m_deny[s] && cur == m_acc[s] + 3;
   endfunction

   always @(negedge clock) begin
      int cur;
      if (!reset) begin
         cur = m_edge + 1;
         chk_b("car_entered",        bus.car_entered,        exp_pulse(0, cur));
         chk_b("is_uni_car_entered", bus.is_uni_car_entered, exp_pulse(0, cur) && m_uni[0]);
         chk_b("car_exited",         bus.car_exited,         exp_pulse(1, cur));
         chk_b("is_uni_car_exited",  bus.is_uni_car_exited,  exp_pulse(1, cur) && m_uni[1]);
         chk_b("entry_gate_open",    bus.entry_gate_open,    exp_open(0, cur));
         chk_b("exit_gate_open",     bus.exit_gate_open,     exp_open(1, cur));
         chk_b("entry_denied",       bus.entry_denied,       exp_denied(0, cur));
         chk_b("exit_denied",        bus.exit_denied,        exp_denied(1, cur));
         chk_v("entry_ok_cnt",       32'(bus.entry_ok_cnt),   m_ok[0]);
         chk_v("entry_deny_cnt",     32'(bus.entry_deny_cnt), m_dn[0]);
         chk_v("exit_ok_cnt",        32'(bus.exit_ok_cnt),    m_ok[1]);
         chk_v("exit_deny_cnt",      32'(bus.exit_deny_cnt),  m_dn[1]);
         chk_b("pulse_exclusive",    bus.car_entered && bus.car_exited, 1'b0);
      end
   end

   task automatic nxt();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      bus.entry_req = 0; bus.entry_is_uni = 0; bus.exit_req = 0;
      bus.exit_is_uni = 0; bus.ja_nist = 0; bus.faulty_exit = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      clear_inputs();
      nxt();
      nxt();
      reset = 0;
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      repeat (3) nxt();
      reset = 0;
      chk_v("rst_entry_state", 32'(bus.entry_state), 0);
      chk_v("rst_exit_state",  32'(bus.exit_state),  0);
      chk_v("rst_entry_ok",    32'(bus.entry_ok_cnt), 0);
      chk_b("rst_entry_open",  bus.entry_gate_open, 1'b0);

      // Held uni entry, accepted.
      bus.entry_is_uni = 1; bus.entry_req = 1;
      nxt();
      chk_b("t2_pulse", bus.car_entered, 1'b1);
      chk_b("t2_uni",   bus.is_uni_car_entered, 1'b1);
      bus.entry_is_uni = 0;
      nxt();
      chk_b("t2_pulse_end", bus.car_entered, 1'b0);
      chk_b("t2_uni_end",   bus.is_uni_car_entered, 1'b0);
      chk_b("t2_not_open",  bus.entry_gate_open, 1'b0);
      for (int i = 3; i <= 6; i++) begin
         nxt();
         chk_b("t2_open", bus.entry_gate_open, 1'b1);
      end
      nxt();
      chk_b("t2_closed", bus.entry_gate_open, 1'b0);
      chk_v("t2_ok_cnt", 32'(bus.entry_ok_cnt), 1);
      for (int i = 0; i < 12; i++) begin
         nxt();
         chk_b("t2_no_second_pulse", bus.car_entered, 1'b0);
      end
      bus.entry_req = 0;
      repeat (3) nxt();

      // Single-cycle entry request, lot full.
      do_reset();
      bus.entry_req = 1; bus.ja_nist = 1;
      nxt();
      bus.entry_req = 0;
      chk_b("t3_pulse", bus.car_entered, 1'b1);
      nxt();
      nxt();
      chk_b("t3_denied", bus.entry_denied, 1'b1);
      chk_b("t3_closed", bus.entry_gate_open, 1'b0);
      nxt();
      chk_b("t3_denied_end", bus.entry_denied, 1'b0);
      chk_v("t3_deny_cnt", 32'(bus.entry_deny_cnt), 1);
      chk_v("t3_ok_cnt",   32'(bus.entry_ok_cnt), 0);
      bus.ja_nist = 0;

      // Exit of an unknown car.
      do_reset();
      bus.exit_req = 1; bus.exit_is_uni = 0; bus.faulty_exit = 1;
      nxt();
      bus.exit_req = 0;
      chk_b("t4_pulse", bus.car_exited, 1'b1);
      chk_b("t4_uni",   bus.is_uni_car_exited, 1'b0);
      nxt();
      nxt();
      chk_b("t4_denied", bus.exit_denied, 1'b1);
      nxt();
      chk_v("t4_deny_cnt", 32'(bus.exit_deny_cnt), 1);
      bus.faulty_exit = 0;

      // Simultaneous requests: exit goes first.
      do_reset();
      bus.entry_req = 1; bus.exit_req = 1;
      nxt();
      chk_b("t5_exit_first",  bus.car_exited, 1'b1);
      chk_b("t5_entry_wait",  bus.car_entered, 1'b0);
      nxt();
      chk_b("t5_entry_next",  bus.car_entered, 1'b1);
      chk_b("t5_exit_done",   bus.car_exited, 1'b0);
      bus.entry_req = 0; bus.exit_req = 0;
      repeat (10) nxt();

      // Counter saturation.
      do_reset();
      for (int n = 0; n < 5; n++) begin
         bus.entry_req = 1;
         nxt();
         bus.entry_req = 0;
         repeat (9) nxt();
      end
      chk_v("t6_ok_sat",    32'(bus.entry_ok_cnt), 3);
      chk_v("t6_deny",      32'(bus.entry_deny_cnt), 0);
      chk_v("t6_exit_ok",   32'(bus.exit_ok_cnt), 0);
      chk_v("t6_exit_deny", 32'(bus.exit_deny_cnt), 0);

      // Reset while the entry barrier is open.
      do_reset();
      bus.entry_req = 1;
      repeat (4) nxt();
      chk_b("t1_open_before", bus.entry_gate_open, 1'b1);
      reset = 1;
      #1;
      chk_b("t1_open_async", bus.entry_gate_open, 1'b0);
      chk_v("t1_ok_cnt",     32'(bus.entry_ok_cnt), 0);
      bus.entry_req = 0;
      nxt();
      nxt();
      reset = 0;
      nxt();
      chk_v("t1_entry_idle", 32'(bus.entry_state), 0);
      chk_v("t1_exit_idle",  32'(bus.exit_state), 0);

      // Random traffic.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) bus.entry_req = ~bus.entry_req;
         if ($urandom_range(0, 5) == 0) bus.exit_req  = ~bus.exit_req;
         bus.entry_is_uni = 1'($urandom_range(0, 1));
         bus.exit_is_uni  = 1'($urandom_range(0, 1));
         bus.ja_nist      = ($urandom_range(0, 2) == 0);
         bus.faulty_exit  = ($urandom_range(0, 2) == 0);
         if (c == 1500) reset = 1;
         if (c == 1503) reset = 0;
         nxt();
      end
      clear_inputs();
      repeat (12) nxt();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
